div32_iter: RTL
===============

Name: div32_iter

Overview:
- Iterative radix-2 integer divider; the inverse-operation companion to the vALU pipelined 32-bit multiplier.
- Serves vdiv/vdivu/vrem/vremu lanes.
- Accepts one operand pair per valid/ready handshake and computes quotient and remainder in DATA_WIDTH iterations.
- Returns results through a valid/ready output port with RISC-V divide-by-zero and overflow semantics.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.
- TAG_WIDTH, 4, width of the sideband tag carried from input to output unchanged.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset (low = reset asserted).
- in_valid  input  1  operand pair valid.
- in_ready  output  1  divider can accept; high only in IDLE and only while rst is high.
- in_signed  input  1  1 = signed divide, 0 = unsigned.
- in_a  input  DATA_WIDTH  dividend.
- in_b  input  DATA_WIDTH  divisor.
- in_tag  input  TAG_WIDTH  sideband tag.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- out_quot  output  DATA_WIDTH  quotient.
- out_rem  output  DATA_WIDTH  remainder.
- out_tag  output  TAG_WIDTH  tag of the operation.

Behaviour:
- Reset, asynchronous on rst low:
  - State goes to IDLE.
  - out_valid, out_quot, out_rem, out_tag and all internal registers go to 0.
  - An in-flight operation is discarded with no output.
  - in_ready is 0 while rst is low.
- States and transitions:
  - IDLE: in_ready=1. An edge with in_valid=1 accepts the operation and moves to CALC.
  - CALC: in_ready=0, out_valid=0. One iteration per cycle. Iteration counter runs 0..DATA_WIDTH-1. The edge at count DATA_WIDTH-1 writes the final results and moves to DONE.
  - DONE: out_valid=1 and outputs are stable. An edge with out_ready=1 moves to IDLE. There is no IDLE bypass, so the next accept happens one cycle later at the earliest.
- Capture at accept:
  - Signed mode: dividend and divisor magnitudes are stored; unsigned mode stores the raw values.
  - Stored alongside: sign_a, quotient-negate flag = sign_a XOR sign_b (signed mode only), tag, div-by-zero flag (in_b==0), overflow flag (signed, in_a = most-negative, in_b = all ones).
- Iteration (restoring algorithm):
  - Shift {rem, quot} left by 1.
  - Form trial = rem_shifted − divisor, DATA_WIDTH+1 bits wide.
  - If trial is non-negative: rem ← trial and quot LSB ← 1. Otherwise rem is kept and quot LSB ← 0.
- Final result, applied on the last CALC edge, in priority order:
  1. div-by-zero: quot = all ones, rem = in_a (original value), in both signed and unsigned modes.
  2. overflow: quot = most-negative, rem = 0.
  3. Otherwise: quot is negated if the negate flag is set; rem is negated if sign_a is set (signed mode). Negation is two's complement modulo 2^DATA_WIDTH.
- Latency: out_valid rises exactly DATA_WIDTH cycles after the accept edge (32 for the default).
- Back-pressure: while out_ready=0 in DONE, all outputs hold indefinitely.
- in_valid is ignored outside IDLE. Operands are sampled only on the accept edge, so later changes to in_a, in_b or in_signed have no effect.

Optional Feature:
- Macro: DIV32_SPECIAL_FAST_EN.
- Defined: when the div-by-zero or overflow flag is set at accept, the divider skips CALC. Override results are written on the accept edge itself, and out_valid is high on the following cycle (latency 1).
- Undefined: special cases take the full DATA_WIDTH latency. Results are identical in both builds.

Decomposition:
- Shared package div_pkg:
  - state enum {IDLE, CALC, DONE};
  - localparam CNT_W = $clog2(DATA_WIDTH);
  - most-negative and all-ones constant functions of the width.
- One sub-module, div_step: combinational single restoring iteration. Inputs are rem, quot and divisor; outputs are next rem and next quot. It is instanced once in div32_iter.

Test Plan:
- Unsigned 100 / 7, tag 5 -> quot 14, rem 2, tag 5; out_valid exactly 32 cycles after accept.
- Signed −7 / 2 -> quot 0xFFFFFFFD (−3), rem 0xFFFFFFFF (−1); signed 7 / −2 -> quot −3, rem 1.
- Divide-by-zero with signed in_a = −5, in_b = 0 -> quot 0xFFFFFFFF, rem 0xFFFFFFFB. Latency is 32 without DIV32_SPECIAL_FAST_EN and 1 with it.
- Overflow, signed 0x80000000 / 0xFFFFFFFF -> quot 0x80000000, rem 0. The same operands unsigned -> quot 0, rem 0x80000000.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout. With in_valid held high, the next accept occurs one cycle after the out_ready edge.
- Reset mid-CALC: drive rst low at iteration 15 -> out_valid=0, outputs 0, in_ready=0 during reset. After release, in_ready=1 and a new 9 / 3 returns quot 3, rem 0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative radix-2 divider.
// The fast special-case path is controlled by DIV32_SPECIAL_FAST_EN.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DIV_WIDTH = 32;
   localparam int CNT_W     = $clog2(DIV_WIDTH);

   // Counter width for a given operand width (at least one bit)
   function automatic int cnt_width(input int w);
      cnt_width = (w > 1) ? $clog2(w) : 1;
   endfunction

   // Most-negative two's complement value of width w (LSB-aligned)
   function automatic logic [63:0] most_neg(input int w);
      most_neg = 64'd1 << (w - 1);
   endfunction

   // All-ones value of width w (LSB-aligned)
   function automatic logic [63:0] all_ones(input int w);
      all_ones = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration on a shifted {rem, quot} pair.
// Purely combinational; the caller registers the results.
module div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] quot,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_nxt,
   output logic [W-1:0] quot_nxt
);

   logic [W:0] shifted;
   logic [W:0] trial;

   // Shift in the next dividend bit and try subtracting the divisor
   always_comb begin
      shifted  = {rem, quot[W-1]};
      trial    = shifted - {1'b0, divisor};
      quot_nxt = {quot[W-2:0], ~trial[W]};
      rem_nxt  = trial[W] ? shifted[W-1:0] : trial[W-1:0];
   end

endmodule

// File: rtl/div32_iter.sv
// Iterative radix-2 signed/unsigned divider with RISC-V special cases.
// Define DIV32_SPECIAL_FAST_EN to finish div-by-zero/overflow at accept.
module div32_iter
   import div_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_signed,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_quot,
   output logic [DATA_WIDTH-1:0] out_rem,
   output logic [TAG_WIDTH-1:0]  out_tag
);

   localparam int CW = cnt_width(DATA_WIDTH);
   localparam logic [63:0] MN64 = most_neg(DATA_WIDTH);
   localparam logic [63:0] AO64 = all_ones(DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0] MOST_NEG = MN64[DATA_WIDTH-1:0];
   localparam logic [DATA_WIDTH-1:0] ONES     = AO64[DATA_WIDTH-1:0];
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   state_t state, nxt;

   logic [CW-1:0]         cnt;
   logic [DATA_WIDTH-1:0] rem;
   logic [DATA_WIDTH-1:0] quot;
   logic [DATA_WIDTH-1:0] divisor;
   logic [DATA_WIDTH-1:0] a_orig;
   logic [TAG_WIDTH-1:0]  tag;
   logic                  sign_a;
   logic                  neg_q;
   logic                  dz;
   logic                  ovf;

   logic                  sa, sb;
   logic [DATA_WIDTH-1:0] mag_a, mag_b;
   logic                  acc_dz, acc_ovf;
   logic [DATA_WIDTH-1:0] step_rem, step_quot;
   logic [DATA_WIDTH-1:0] fin_q, fin_r;
   logic                  last;
   logic                  accept;

   div_step #(.W(DATA_WIDTH)) u_step (
      .rem      (rem),
      .quot     (quot),
      .divisor  (divisor),
      .rem_nxt  (step_rem),
      .quot_nxt (step_quot)
   );

   // Operand conditioning at accept: magnitudes and special-case flags
   always_comb begin
      sa      = in_signed & in_a[DATA_WIDTH-1];
      sb      = in_signed & in_b[DATA_WIDTH-1];
      mag_a   = sa ? -in_a : in_a;
      mag_b   = sb ? -in_b : in_b;
      acc_dz  = (in_b == '0);
      acc_ovf = in_signed & (in_a == MOST_NEG) & (in_b == ONES);
   end

   // Final result selection, applied on the last iteration edge
   always_comb begin
      last = (cnt == LAST);
      if (dz) begin
         fin_q = ONES;
         fin_r = a_orig;
      end else if (ovf) begin
         fin_q = MOST_NEG;
         fin_r = '0;
      end else begin
         fin_q = neg_q ? -step_quot : step_quot;
         fin_r = sign_a ? -step_rem : step_rem;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   // Next-state and handshake outputs
   always_comb begin
      nxt       = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = rst;
            accept   = in_valid;
            if (in_valid) begin
`ifdef DIV32_SPECIAL_FAST_EN
               nxt = (acc_dz | acc_ovf) ? DONE : CALC;
`else
               nxt = CALC;
`endif
            end
         end
         CALC: begin
            if (last) nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // Datapath: capture at accept, iterate in CALC, write results at end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         rem      <= '0;
         quot     <= '0;
         divisor  <= '0;
         a_orig   <= '0;
         tag      <= '0;
         sign_a   <= 1'b0;
         neg_q    <= 1'b0;
         dz       <= 1'b0;
         ovf      <= 1'b0;
         out_quot <= '0;
         out_rem  <= '0;
         out_tag  <= '0;
      end else if (accept) begin
         cnt     <= '0;
         rem     <= '0;
         quot    <= mag_a;
         divisor <= mag_b;
         a_orig  <= in_a;
         tag     <= in_tag;
         sign_a  <= sa;
         neg_q   <= sa ^ sb;
         dz      <= acc_dz;
         ovf     <= acc_ovf;
`ifdef DIV32_SPECIAL_FAST_EN
         if (acc_dz | acc_ovf) begin
            out_quot <= acc_dz ? ONES : MOST_NEG;
            out_rem  <= acc_dz ? in_a : '0;
            out_tag  <= in_tag;
         end
`endif
      end else if (state == CALC) begin
         rem  <= step_rem;
         quot <= step_quot;
         cnt  <= cnt + 1'b1;
         if (last) begin
            out_quot <= fin_q;
            out_rem  <= fin_r;
            out_tag  <= tag;
         end
      end
   end

endmodule
